// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port-A arbiter.
// FSM state encodings, burst-counter width and a one-hot to index helper.
package ram_port_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int unsigned CNT_W = 4;

   // Index of the set bit in a one-hot vector of up to 8 requesters
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// arb_rr_pick: combinational rotating-priority picker.
// Returns a one-hot pick of the first requester at or after 'start' (wrapping),
// ignoring any requester flagged in 'excl'. Fixed priority is start = 0.
module arb_rr_pick #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   start,
   input  logic [N-1:0] excl,
   output logic [N-1:0] pick
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  elig;
   logic [IW-1:0] idx;
   logic          found;

   assign elig = req & ~excl;

   // Walk the requesters starting at 'start' and keep the first eligible one
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = IW'((32'(start) + i) % N);
         if (!found && elig[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants one of N requesters per cycle onto RAM port A,
// with burst locking bounded by MAX_BURST, registered low-active RAM command
// pins and a two-stage tagged read-return pipeline.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed priority, index 0 highest).
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned N         = 3,
   parameter int unsigned AW        = 8,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_i,
   input  logic [N-1:0]    we_i,
   input  logic [N*AW-1:0] addr_i,
   input  logic [N*DW-1:0] wdata_i,
   output logic [N-1:0]    gnt_o,
   output logic [N-1:0]    rvalid_o,
   output logic [DW-1:0]   rdata_o,
   output logic            cen_o,
   output logic            wen_o,
   output logic            oen_o,
   output logic [AW-1:0]   addr_o,
   output logic [DW-1:0]   wdata_o,
   input  logic [DW-1:0]   rdata_i
);

   arb_state_e       state;
   logic [2:0]       owner;
   logic [CNT_W-1:0] count;

   logic [N-1:0]     owner_oh;
   logic [N-1:0]     excl;
   logic [N-1:0]     pick;
   logic [N-1:0]     gnt;
   logic [2:0]       start;
   logic [2:0]       gnt_idx;
   logic             at_limit;
   logic             others_pending;
   logic             owner_hold;

   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_wdata;

   logic             rd_v1;
   logic             rd_v2;
   logic [N-1:0]     rd_tag1;
   logic [N-1:0]     rd_tag2;

   assign owner_oh       = (state == BURST) ? ({{(N-1){1'b0}}, 1'b1} << owner) : '0;
   assign at_limit       = (count >= CNT_W'(MAX_BURST));
   assign others_pending = |(req_i & ~owner_oh);
   // Once the owner has used its burst allowance, it is skipped only if someone else waits
   assign excl           = (state == BURST && at_limit && others_pending) ? owner_oh : '0;

`ifdef ARB_FIXED_PRIO_EN
   // Fixed priority: search always starts at index 0, the owner has no hold priority
   assign start      = 3'd0;
   assign owner_hold = 1'b0;
`else
   logic [2:0] ptr;

   assign start      = ptr;
   assign owner_hold = (state == BURST) && (|(req_i & owner_oh)) && !at_limit;

   // Round-robin pointer moves to one past the most recent grantee
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (|gnt) begin
         ptr <= (gnt_idx == 3'(N - 1)) ? 3'd0 : gnt_idx + 3'd1;
      end
   end
`endif

   arb_rr_pick #(.N(N)) u_pick (
      .req   (req_i),
      .start (start),
      .excl  (excl),
      .pick  (pick)
   );

   assign gnt     = rst ? '0 : (owner_hold ? owner_oh : pick);
   assign gnt_idx = oh2idx(8'(gnt));
   assign gnt_o   = gnt;

   // Burst FSM: a grant to a new requester opens a burst, repeat grants count up and saturate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         count <= '0;
      end else if (|gnt) begin
         state <= BURST;
         owner <= gnt_idx;
         if (state == BURST && gnt_idx == owner) begin
            count <= at_limit ? count : count + CNT_W'(1);
         end else begin
            count <= CNT_W'(1);
         end
      end else begin
         state <= IDLE;
         count <= '0;
      end
   end

   // Route the grantee's address and write data towards the command register
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (gnt[k]) begin
            sel_addr  = addr_i[k*AW +: AW];
            sel_wdata = wdata_i[k*DW +: DW];
         end
      end
   end

   // Command stage: drive the RAM pins one cycle after the grant; address/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cen_o   <= 1'b1;
         wen_o   <= 1'b1;
         addr_o  <= '0;
         wdata_o <= '0;
      end else begin
         cen_o <= ~(|gnt);
         wen_o <= ~(|(gnt & we_i));
         if (|gnt) begin
            addr_o  <= sel_addr;
            wdata_o <= sel_wdata;
         end
      end
   end

   // Read-return pipeline: tag enters at a read grant and surfaces two cycles later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v1   <= 1'b0;
         rd_v2   <= 1'b0;
         rd_tag1 <= '0;
         rd_tag2 <= '0;
      end else begin
         rd_v1   <= |(gnt & ~we_i);
         rd_tag1 <= gnt & ~we_i;
         rd_v2   <= rd_v1;
         rd_tag2 <= rd_tag1;
      end
   end

   assign oen_o    = ~rd_v2;
   assign rvalid_o = rd_v2 ? rd_tag2 : '0;
   assign rdata_o  = rdata_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (MAX_BURST 4 and a small limit)
// share directed stimulus; a behavioural model predicts every output each cycle
// and literal checks pin the model to hand-worked scenarios.
module tb_ram_port_arbiter;

   localparam int unsigned N   = 3;
   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned MB0 = 4;
`ifdef ARB_FIXED_PRIO_EN
   localparam int unsigned MB1 = 2;
`else
   localparam int unsigned MB1 = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;

   logic [N-1:0]    gnt    [2];
   logic [N-1:0]    rvalid [2];
   logic [DW-1:0]   rdata  [2];
   logic [DW-1:0]   ram_q  [2];
   logic [DW-1:0]   wdo    [2];
   logic [AW-1:0]   ao     [2];
   logic            cen    [2];
   logic            wen    [2];
   logic            oen    [2];

   logic [DW-1:0]   ram  [2][256];
   bit              ramw [2][256];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MB0)) dut0 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .cen_o(cen[0]),
      .wen_o(wen[0]), .oen_o(oen[0]), .addr_o(ao[0]), .wdata_o(wdo[0]), .rdata_i(ram_q[0])
   );

   ram_port_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MB1)) dut1 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .cen_o(cen[1]),
      .wen_o(wen[1]), .oen_o(oen[1]), .addr_o(ao[1]), .wdata_o(wdo[1]), .rdata_i(ram_q[1])
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return (a == 8'h15) ? 32'hDEADBEEF : {24'hA5A5A5, a};
   endfunction

   function automatic bit bit_of(input logic [N-1:0] v, input int i);
      return ((int'(v) >> i) & 1) == 1;
   endfunction

   // Synchronous single-port RAM behind each instance's port A
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!cen[i]) begin
            if (!wen[i]) begin
               ram[i][ao[i]]  <= wdo[i];
               ramw[i][ao[i]] <= 1'b1;
            end else begin
               ram_q[i] <= ramw[i][ao[i]] ? ram[i][ao[i]] : init_val(ao[i]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: which requester wins, from the arbitration rules
   function automatic int model_pick(input logic [N-1:0] r, input int own, input int rn,
                                     input int nx, input int mb);
      bit others;
      int start;
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != own && bit_of(r, j)) others = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = nx;
      if (own >= 0 && bit_of(r, own) && rn < mb) return own;
`endif
      for (int s = 0; s < N; s++) begin
         int idx;
         idx = (start + s) % N;
         if (bit_of(r, idx) && !(idx == own && rn >= mb && others)) return idx;
      end
      return -1;
   endfunction

   int            m_owner [2];
   int            m_run   [2];
   int            m_nxt   [2];
   logic          m_cen   [2];
   logic          m_wen   [2];
   logic [AW-1:0] m_addr  [2];
   logic [DW-1:0] m_wd    [2];
   logic [N-1:0]  m_t1    [2];
   logic [N-1:0]  m_t2    [2];
   logic [DW-1:0] m_d1    [2];
   logic [DW-1:0] m_d2    [2];
   logic [DW-1:0] mm      [2][256];
   bit            mmw     [2][256];

   // Compare process: every falling edge, check all outputs against the model, then advance it
   initial begin : compare
      int            g;
      int            mb;
      logic [N-1:0]  eg;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            mb = (i == 0) ? int'(MB0) : int'(MB1);
            if (rst) begin
               chk($sformatf("rst_gnt%0d", i), gnt[i], 0);
               chk($sformatf("rst_rvalid%0d", i), rvalid[i], 0);
               chk($sformatf("rst_cen%0d", i), cen[i], 1);
               chk($sformatf("rst_wen%0d", i), wen[i], 1);
               chk($sformatf("rst_oen%0d", i), oen[i], 1);
               m_owner[i] = -1; m_run[i] = 0; m_nxt[i] = 0;
               m_cen[i] = 1'b1; m_wen[i] = 1'b1; m_addr[i] = '0; m_wd[i] = '0;
               m_t1[i] = '0; m_t2[i] = '0; m_d1[i] = '0; m_d2[i] = '0;
            end else begin
               chk($sformatf("cen%0d", i), cen[i], m_cen[i]);
               chk($sformatf("wen%0d", i), wen[i], m_wen[i]);
               chk($sformatf("addr%0d", i), ao[i], m_addr[i]);
               chk($sformatf("wdata%0d", i), wdo[i], m_wd[i]);
               chk($sformatf("oen%0d", i), oen[i], (m_t2[i] == 0));
               chk($sformatf("rvalid%0d", i), rvalid[i], m_t2[i]);
               if (m_t2[i] != 0) chk($sformatf("rdata%0d", i), rdata[i], m_d2[i]);
               g  = model_pick(req, m_owner[i], m_run[i], m_nxt[i], mb);
               eg = '0;
               if (g >= 0) eg[g] = 1'b1;
               chk($sformatf("gnt%0d", i), gnt[i], eg);
               m_t2[i] = m_t1[i];
               m_d2[i] = m_d1[i];
               m_t1[i] = '0;
               if (g >= 0) begin
                  a = addr[g*AW +: AW];
                  d = wdata[g*DW +: DW];
                  m_cen[i]  = 1'b0;
                  m_wen[i]  = !bit_of(we, g);
                  m_addr[i] = a;
                  m_wd[i]   = d;
                  if (bit_of(we, g)) begin
                     mm[i][a]  = d;
                     mmw[i][a] = 1'b1;
                  end else begin
                     m_t1[i] = eg;
                     m_d1[i] = mmw[i][a] ? mm[i][a] : init_val(a);
                  end
                  if (g == m_owner[i]) m_run[i] = (m_run[i] + 1 > mb) ? mb : m_run[i] + 1;
                  else begin
                     m_owner[i] = g;
                     m_run[i]   = 1;
                  end
                  m_nxt[i] = (g + 1) % N;
               end else begin
                  m_cen[i]   = 1'b1;
                  m_wen[i]   = 1'b1;
                  m_owner[i] = -1;
                  m_run[i]   = 0;
               end
            end
         end
      end
   end

   task automatic set_port(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr[k*AW +: AW]  = a;
      wdata[k*DW +: DW] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [N-1:0] rr_exp    [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [N-1:0] burst_exp [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
   logic [N-1:0] fp_exp    [6] = '{3'b010, 3'b010, 3'b100, 3'b010, 3'b010, 3'b100};
   logic [N-1:0] mix_req   [6] = '{3'b011, 3'b110, 3'b101, 3'b111, 3'b010, 3'b100};
   logic [N-1:0] mix_we    [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b000, 3'b100};

   // Directed stimulus with hand-worked expectations
   initial begin : stim
      rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
      #1 rst = 1'b1;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk("init_gnt", gnt[i], 3'b000);
         chk("init_rvalid", rvalid[i], 3'b000);
         chk("init_cen", cen[i], 1'b1);
         chk("init_wen", wen[i], 1'b1);
         chk("init_oen", oen[i], 1'b1);
         chk("init_addr", ao[i], 8'h00);
         chk("init_wdata", wdo[i], 32'h0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Round-robin fairness, all three reading
      for (int k = 0; k < N; k++) set_port(k, 8'(8'h40 + k), 32'h0);
      next_cycle();
      req = 3'b111; we = 3'b000;
      for (int c = 0; c < 6; c++) begin
         #1;
`ifndef ARB_FIXED_PRIO_EN
         chk($sformatf("rr_c%0d", c), gnt[1], rr_exp[c]);
`endif
         next_cycle();
      end
      req = '0;
      repeat (4) next_cycle();

      // Reset while a read is in flight
      set_port(0, 8'h15, 32'h0);
      req = 3'b001; we = 3'b000;
      next_cycle();
      req = '0;
      chk("pre_rst_cen", cen[0], 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_now_cen", cen[0], 1'b1);
      chk("rst_now_wen", wen[0], 1'b1);
      chk("rst_now_oen", oen[0], 1'b1);
      chk("rst_now_rvalid", rvalid[0], 3'b000);
      chk("rst_now_gnt", gnt[0], 3'b000);
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 chk($sformatf("rst_drop_rv%0d", c), rvalid[0], 3'b000);
         next_cycle();
      end

      // Single read of preloaded word
      set_port(1, 8'h15, 32'h0);
      req = 3'b010; we = 3'b000;
      #1 chk("rd_gnt", gnt[0], 3'b010);
      next_cycle();
      req = '0; set_port(1, 8'h77, 32'h0);
      #1;
      chk("rd_cen", cen[0], 1'b0);
      chk("rd_wen", wen[0], 1'b1);
      chk("rd_addr", ao[0], 8'h15);
      next_cycle();
      #1;
      chk("rd_rvalid", rvalid[0], 3'b010);
      chk("rd_rdata", rdata[0], 32'hDEADBEEF);
      chk("rd_oen", oen[0], 1'b0);
      repeat (2) next_cycle();

      // Write then read of the same address
      set_port(0, 8'h20, 32'h12345678);
      req = 3'b001; we = 3'b001;
      #1 chk("wr_gnt", gnt[0], 3'b001);
      next_cycle();
      set_port(1, 8'h20, 32'h0);
      req = 3'b010; we = 3'b000;
      #1;
      chk("wr_rd_gnt", gnt[0], 3'b010);
      chk("wr_cen", cen[0], 1'b0);
      chk("wr_wen", wen[0], 1'b0);
      chk("wr_addr", ao[0], 8'h20);
      chk("wr_wdata", wdo[0], 32'h12345678);
      next_cycle();
      req = '0;
      next_cycle();
      #1;
      chk("wr_rd_rvalid", rvalid[0], 3'b010);
      chk("wr_rd_rdata", rdata[0], 32'h12345678);
      repeat (2) next_cycle();

      // Burst limit: req0 streams writes, req2 reads from cycle 2 until served
      set_port(2, 8'h20, 32'h0);
      for (int c = 0; c < 6; c++) begin
         set_port(0, 8'(8'h30 + c), 32'hB0000000 + 32'(c));
         req = (c >= 2 && c <= 4) ? 3'b101 : 3'b001;
         we  = 3'b001;
         #1 chk($sformatf("burst_c%0d", c), gnt[0], burst_exp[c]);
         next_cycle();
      end
      req = '0; we = '0;
      repeat (3) next_cycle();

`ifdef ARB_FIXED_PRIO_EN
      // Fixed priority with burst limit 2
      req = 3'b110; we = 3'b000;
      for (int c = 0; c < 6; c++) begin
         #1 chk($sformatf("fp_c%0d", c), gnt[1], fp_exp[c]);
         next_cycle();
      end
      req = '0;
      repeat (3) next_cycle();
`endif

      // Back-to-back mixed reads and writes
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < N; k++) set_port(k, 8'(8'h50 + 4 * c + k), 32'hC0DE0000 + 32'(16 * c + k));
         req = mix_req[c]; we = mix_we[c];
         next_cycle();
      end
      req = '0; we = '0;
      repeat (4) next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Arbitrates N requesters onto port A of a single dual-port RAM, and sequences the RAM's low-active control pins. Each requester can read or write. The arbiter grants one requester per cycle, with bounded burst locking, registers the RAM command, and returns read data tagged to the originating requester. It sits between the encoder pipeline stages that share one on-chip buffer (e.g. fetch writes, motion-estimation reads) and that buffer's port A.

## Interface
- N, 3, number of requesters (2..8)
- AW, 8, RAM address width
- DW, 32, RAM word width
- MAX_BURST, 4, max consecutive grants to one requester while others wait (1..15)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_i  in  N  per-requester access request; held until granted
- we_i  in  N  per-requester write (1) / read (0)
- addr_i  in  N*AW  per-requester address, requester k at [k*AW +: AW]
- wdata_i  in  N*DW  per-requester write data, same packing
- gnt_o  out  N  one-hot grant (combinational, same cycle as accepted req)
- rvalid_o  out  N  one-hot read-data valid
- rdata_o  out  DW  read data, qualified by rvalid_o
- cen_o  out  1  RAM chip enable, low active
- wen_o  out  1  RAM write enable, low active
- oen_o  out  1  RAM output enable, low active
- addr_o  out  AW  RAM address
- wdata_o  out  DW  RAM write data
- rdata_i  in  DW  RAM read data

## Operation
- Grant: at most one gnt_o bit per cycle, and only to a requester with req_i high; gnt_o[k] means requester k's command is accepted this cycle.
- Arbitration: round-robin. The pointer advances to one past the last granted index, and search starts at the pointer.
- FSM states: IDLE, BURST.
  - IDLE -> BURST on any grant; the burst counter is loaded with 1 and owner = grantee.
  - In BURST, the owner keeps priority while req_i[owner] is high and count < MAX_BURST; the counter increments on each grant.
  - BURST -> IDLE when the owner drops req, or when count reaches MAX_BURST while another req is pending. In that case the next grant in the same cycle goes round-robin, excluding the owner.
  - If count reaches MAX_BURST and no other requester is pending, the owner continues and the counter saturates.
- Command stage: on a grant, cen_o=0, wen_o=~we, addr_o and wdata_o are registered from the grantee. With no grant, cen_o=1 and wen_o=1; addr_o and wdata_o hold their previous values.
- Read return: a 2-bit-deep pipeline of {valid, one-hot tag}.
  - The tag enters at the grant of a read.
  - oen_o=0 only in the cycle the RAM drives data, i.e. when the stage-2 valid is set; otherwise 1.
  - rdata_o = rdata_i unmodified. rvalid_o = stage-2 tag when stage-2 valid, else 0.
- Writes produce no rvalid_o.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, cen_o=1, wen_o=1, oen_o=1, addr_o=0, wdata_o=0.
- Internal reset state: FSM=IDLE, pointer=0, count=0, read pipeline cleared.
- Read latency: req/gnt in cycle t -> RAM command on pins in t+1 -> rvalid_o and rdata_o in t+2.
- Write: gnt in t -> cen_o=0 and wen_o=0 in t+1; the RAM writes at the end of t+1.
- Throughput: one command per cycle, back-to-back, any mix of reads and writes.
- A requester may change addr_i, we_i or req_i in the cycle after gnt.
- Reset asserted mid-operation: in-flight reads are discarded (no rvalid_o afterwards), and the pins return to idle immediately (asynchronously).
- Simultaneous requests with the pointer at k: the lowest index ≥ k (mod N) wins.

## Configuration
- ARB_FIXED_PRIO_EN:
  - When defined, round-robin is replaced by fixed priority (index 0 highest). The burst limit still applies, so a low-priority requester can only be starved by higher-priority requesters, never by an owner exceeding MAX_BURST.
  - When undefined, round-robin as above.

## Structure
- Shared package/defines file: FSM state encodings (IDLE=1'b0, BURST=1'b1) and the burst-count width constant (4 bits).
- One sub-module: arb_rr_pick. It is combinational: it takes a request vector, a start pointer and an exclude mask, and returns a one-hot pick. The fixed-priority variant is this same module with the pointer forced to 0.

## Test plan
- Reset: assert rst mid-stream -> cen_o=1, wen_o=1, oen_o=1, rvalid_o=0 immediately; a read granted the cycle before reset never returns rvalid.
- Single read: req_i=3'b010, we=0, addr=8'h15, RAM preloaded with 32'hDEADBEEF -> gnt_o=010 in t, cen_o=0/wen_o=1/addr_o=15 in t+1, rvalid_o=010 and rdata_o=DEADBEEF in t+2.
- Write then read same address: req0 writes 32'h12345678 to 8'h20 in t, req1 reads 8'h20 in t+1 -> rvalid_o=010 with 12345678 in t+3.
- Round-robin fairness: req_i=3'b111 held 6 cycles with MAX_BURST=1 -> grant sequence 001,010,100,001,010,100.
- Burst limit: req0 held continuously and req2 asserted at cycle 2, MAX_BURST=4 -> req0 gets 4 consecutive grants, req2 is granted in cycle 4, then req0 resumes.
- ARB_FIXED_PRIO_EN defined: req_i=3'b110 held, MAX_BURST=2 -> grants 010,010,100,010,010,100.
